mem_responder: RTL and testbench
================================

# mem_responder

Byte-wide memory and I/O responder on the CPU's shared memory bus, the device side of the `mem_a` / `mem_dout` / `mem_wr` / `mem_din` interface driven by the load/store buffer and instruction fetch. It serves one byte per cycle from an on-chip RAM with fixed one-cycle read latency and decodes a small I/O window. The window provides a UART transmit FIFO, a receive byte port, a cycle-counter snapshot and a simulation-halt register. The responder never stalls a bus transaction; backpressure is advisory via `io_buffer_full`.

## Interface
- `ADDR_WIDTH`, 17: RAM byte-address width (128 KiB).
- `TX_DEPTH`, 16: transmit FIFO entries, power of two.
- `TX_WIDTH`, 4: log2(`TX_DEPTH`).

Ports:
- `clk_in`  input  1  clock. One clock; all state updates on its rising edge.
- `rst_in`  input  1  reset. Asynchronous, active-high.
- `rdy_in`  input  1  global enable; when low, all state holds.
- `mem_a`  input  32  byte address from CPU.
- `mem_wr`  input  1  1 = write, 0 = read.
- `mem_dout`  input  8  write data from CPU.
- `mem_din`  output  8  read data to CPU.
- `io_buffer_full`  output  1  TX FIFO almost full; CPU must hold I/O writes.
- `tx_valid`  output  1  TX FIFO head byte valid.
- `tx_data`  output  8  TX FIFO head byte.
- `tx_ready`  input  1  UART accepts head byte this cycle.
- `rx_valid`  input  1  UART receive byte available.
- `rx_data`  input  8  UART receive byte.
- `rx_pop`  output  1  one-cycle pulse consuming `rx_data`.
- `sim_done`  output  1  sticky halt flag.
- `exit_code`  output  8  byte written to the halt register.
- `tx_overflow`  output  1  sticky; a TX write was dropped.

## Operation
- Decode: `mem_a[17:16] == 2'b11` selects I/O; otherwise RAM at `mem_a[ADDR_WIDTH-1:0]`. Upper address bits are ignored.
- RAM write: `mem_wr=1`, RAM selected → byte stored at the edge.
- RAM read: `mem_din` is the addressed byte on the next cycle.
- RAM contents are not reset.
- I/O write 0x30000:
  - Push `mem_dout` into the TX FIFO.
  - If the FIFO is full and no pop occurs the same cycle, drop the byte and set `tx_overflow`.
- I/O write 0x30004: set `sim_done`; `exit_code <= mem_dout`. Later writes update `exit_code` only.
- I/O read 0x30000:
  - If `rx_valid`, next-cycle `mem_din = rx_data` and `rx_pop` pulses for one cycle, aligned with that edge.
  - Otherwise return 0 with no pop.
- I/O read 0x30004: captures the 32-bit cycle counter into a snapshot and returns snapshot byte 0.
- I/O reads 0x30005–0x30007 return snapshot bytes 1–3 without re-capturing.
- Other I/O addresses: reads return 0; writes are ignored.
- Cycle counter: 32-bit, increments every cycle with `rdy_in=1`, wraps at 2^32.
- TX FIFO:
  - Circular buffer with head and tail pointers of width `TX_WIDTH` and a count of width `TX_WIDTH+1`.
  - `tx_valid = (count != 0)`; pop when `tx_valid && tx_ready`.
  - A push and a pop in the same cycle leave count unchanged. This also applies when full: the push is accepted.
- `io_buffer_full = (count >= TX_DEPTH-2)`. This reserves one cycle of in-flight writes plus one slot.
- `rdy_in=0`: no memory write, no FIFO push or pop, counter holds, `rx_pop=0`, and `mem_din` holds its value.

## Timing
- Reset values:
  - `mem_din=0`, `tx_valid=0`, `tx_data=0`, `io_buffer_full=0`.
  - `rx_pop=0`, `sim_done=0`, `exit_code=0`, `tx_overflow=0`.
  - FIFO empty, counter 0, snapshot 0.
- Read latency is exactly 1 cycle for both RAM and I/O. Back-to-back reads return one byte per cycle in address order.
- A write followed by a read of the same RAM address on the next cycle returns the new byte.
- A TX push at edge N makes `tx_valid=1` after edge N when the FIFO was empty. `tx_data` is the head entry and is combinational from the FIFO array.
- Reset asserted mid-transaction clears all state immediately. The pending read result is lost, and `mem_din` returns to 0.
- The counter snapshot taken on a 0x30004 read at edge N holds the counter value before increment at N.

## Test plan
- Write 0xA5 to 0x00010, then read 0x00010 → `mem_din=0xA5` exactly one cycle after the read address.
- Write 4 bytes to 0x00100–0x00103, then read them back-to-back → 4 consecutive cycles return the bytes in order.
- Write 0x48, 0x69 to 0x30000 with `tx_ready=0` → `tx_valid=1`, `tx_data=0x48`. Raise `tx_ready` for 1 cycle → `tx_data=0x69`, count 1.
- With `tx_ready=0`, write 16 bytes:
  - `io_buffer_full=1` after the 14th byte.
  - A 17th write sets `tx_overflow=1`, and the FIFO still holds the first 16 bytes.
- `rx_valid=1`, `rx_data=0x3C`, read 0x30000 → next-cycle `mem_din=0x3C` with a single-cycle `rx_pop`. With `rx_valid=0`, a read returns 0 and `rx_pop` stays 0.
- After 100 enabled cycles, read 0x30004 → returns 0x64 (low byte of 100). Write 0x07 to 0x30004 → `sim_done=1`, `exit_code=0x07`. Assert `rst_in` → all outputs 0 immediately.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: byte-wide device side of the CPU shared memory bus.
// Serves an on-chip RAM with one-cycle read latency and a small I/O window
// holding the UART TX FIFO, the RX byte port, a cycle-counter snapshot and
// the simulation-halt register. Bus transactions are never stalled.
module mem_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 16,
    parameter int TX_WIDTH   = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        sim_done,
    output logic [7:0]  exit_code,
    output logic        tx_overflow
);

    localparam logic [15:0] OFF_UART   = 16'h0000;
    localparam logic [15:0] OFF_HALT   = 16'h0004;
    localparam logic [15:0] OFF_SNAP1  = 16'h0005;
    localparam logic [15:0] OFF_SNAP2  = 16'h0006;
    localparam logic [15:0] OFF_SNAP3  = 16'h0007;
    localparam logic [TX_WIDTH:0] FULL_COUNT   = (TX_WIDTH+1)'(TX_DEPTH);
    localparam logic [TX_WIDTH:0] ALMOST_COUNT = (TX_WIDTH+1)'(TX_DEPTH - 2);

    logic [7:0]            ram [0:(1<<ADDR_WIDTH)-1];
    logic [7:0]            txMem [0:TX_DEPTH-1];

    logic                  ioSel;
    logic [15:0]           ioOff;
    logic [ADDR_WIDTH-1:0] ramAddr;
    logic                  ramWe;
    logic                  txPush;
    logic                  txPop;
    logic                  txAccept;
    logic                  haltWe;
    logic                  rxRead;
    logic                  snapCap;
    logic                  ioAddr_unused;

    logic [7:0]            memDin_q, memDin_d;
    logic [31:0]           cycleCnt_q, cycleCnt_d;
    logic [31:0]           snap_q, snap_d;
    logic [TX_WIDTH-1:0]   txHead_q, txHead_d;
    logic [TX_WIDTH-1:0]   txTail_q, txTail_d;
    logic [TX_WIDTH:0]     txCount_q, txCount_d;
    logic                  txOverflow_q, txOverflow_d;
    logic                  simDone_q, simDone_d;
    logic [7:0]            exitCode_q, exitCode_d;

    // Upper address bits take no part in decoding.
    assign ioAddr_unused = ^mem_a[31:18];

    assign ioSel   = (mem_a[17:16] == 2'b11);
    assign ioOff   = mem_a[15:0];
    assign ramAddr = mem_a[ADDR_WIDTH-1:0];

    assign ramWe    = rdy_in && mem_wr && !ioSel;
    assign txPush   = rdy_in && mem_wr && ioSel && (ioOff == OFF_UART);
    assign haltWe   = rdy_in && mem_wr && ioSel && (ioOff == OFF_HALT);
    assign rxRead   = rdy_in && !mem_wr && ioSel && (ioOff == OFF_UART);
    assign snapCap  = rdy_in && !mem_wr && ioSel && (ioOff == OFF_HALT);
    assign txPop    = rdy_in && tx_valid && tx_ready;
    assign txAccept = txPush && ((txCount_q != FULL_COUNT) || txPop);

    assign mem_din        = memDin_q;
    assign tx_valid       = (txCount_q != '0);
    assign tx_data        = tx_valid ? txMem[txHead_q] : 8'h00;
    assign io_buffer_full = (txCount_q >= ALMOST_COUNT);
    assign rx_pop         = rxRead && rx_valid && !rst_in;
    assign sim_done       = simDone_q;
    assign exit_code      = exitCode_q;
    assign tx_overflow    = txOverflow_q;

    // RAM write port; contents are deliberately left unreset.
    always_ff @(posedge clk_in) begin
        if (ramWe) begin
            ram[ramAddr] <= mem_dout;
        end
    end

    // TX FIFO storage, written at the tail whenever a push is accepted.
    always_ff @(posedge clk_in) begin
        if (txAccept) begin
            txMem[txTail_q] <= mem_dout;
        end
    end

    // Read-data select for the next cycle; holds on writes and when disabled.
    always_comb begin
        memDin_d = memDin_q;
        if (rdy_in && !mem_wr) begin
            if (!ioSel) begin
                memDin_d = ram[ramAddr];
            end else begin
                case (ioOff)
                    OFF_UART:  memDin_d = rx_valid ? rx_data : 8'h00;
                    OFF_HALT:  memDin_d = cycleCnt_q[7:0];
                    OFF_SNAP1: memDin_d = snap_q[15:8];
                    OFF_SNAP2: memDin_d = snap_q[23:16];
                    OFF_SNAP3: memDin_d = snap_q[31:24];
                    default:   memDin_d = 8'h00;
                endcase
            end
        end
    end

    // Free-running cycle counter and the snapshot taken on a halt-address read.
    always_comb begin
        cycleCnt_d = cycleCnt_q;
        snap_d     = snap_q;
        if (rdy_in) begin
            cycleCnt_d = cycleCnt_q + 32'd1;
        end
        if (snapCap) begin
            snap_d = cycleCnt_q;
        end
    end

    // FIFO pointer and occupancy update; a simultaneous push and pop keeps count.
    always_comb begin
        txHead_d     = txHead_q;
        txTail_d     = txTail_q;
        txCount_d    = txCount_q;
        txOverflow_d = txOverflow_q;
        if (txPop) begin
            txHead_d = txHead_q + 1'b1;
        end
        if (txAccept) begin
            txTail_d = txTail_q + 1'b1;
        end
        case ({txAccept, txPop})
            2'b10:   txCount_d = txCount_q + 1'b1;
            2'b01:   txCount_d = txCount_q - 1'b1;
            default: txCount_d = txCount_q;
        endcase
        if (txPush && !txAccept) begin
            txOverflow_d = 1'b1;
        end
    end

    // Halt register: the first write latches sim_done, every write updates the code.
    always_comb begin
        simDone_d  = simDone_q;
        exitCode_d = exitCode_q;
        if (haltWe) begin
            simDone_d  = 1'b1;
            exitCode_d = mem_dout;
        end
    end

    // State registers, all cleared immediately by reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            memDin_q     <= 8'h00;
            cycleCnt_q   <= 32'h0;
            snap_q       <= 32'h0;
            txHead_q     <= '0;
            txTail_q     <= '0;
            txCount_q    <= '0;
            txOverflow_q <= 1'b0;
            simDone_q    <= 1'b0;
            exitCode_q   <= 8'h00;
        end else begin
            memDin_q     <= memDin_d;
            cycleCnt_q   <= cycleCnt_d;
            snap_q       <= snap_d;
            txHead_q     <= txHead_d;
            txTail_q     <= txTail_d;
            txCount_q    <= txCount_d;
            txOverflow_q <= txOverflow_d;
            simDone_q    <= simDone_d;
            exitCode_q   <= exitCode_d;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven bus vectors plus hand-written sequences for
// the TX FIFO, RX port, cycle snapshot, halt register and asynchronous reset.
module tb_mem_responder;

    localparam logic [31:0] IDLE_ADDR = 32'h0000_0010;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        sim_done;
    logic [7:0]  exit_code;
    logic        tx_overflow;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  data;
        logic [7:0]  expData;
    } busVec_t;

    busVec_t    vecs[16];
    logic [7:0] readQ[$];
    logic [7:0] txQ[$];
    int         assertions = 0;
    int         failures   = 0;

    mem_responder #(
        .ADDR_WIDTH(17),
        .TX_DEPTH(16),
        .TX_WIDTH(4)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .mem_a(mem_a),
        .mem_wr(mem_wr),
        .mem_dout(mem_dout),
        .mem_din(mem_din),
        .io_buffer_full(io_buffer_full),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_pop(rx_pop),
        .sim_done(sim_done),
        .exit_code(exit_code),
        .tx_overflow(tx_overflow)
    );

    // 100 MHz clock
    always #5 clk_in = ~clk_in;

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // One bus cycle; a checked read queues its expectation and is compared after the edge
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [7:0] data,
                                 input logic chk, input logic [7:0] exp);
        mem_wr   = wr;
        mem_a    = addr;
        mem_dout = data;
        if (chk && !wr) readQ.push_back(exp);
        @(posedge clk_in);
        #1;
        if (chk && !wr) checkOutput("readData", {24'h0, mem_din}, {24'h0, readQ.pop_front()});
        mem_wr = 1'b0;
        mem_a  = IDLE_ADDR;
    endtask

    // Pop the FIFO until empty, comparing each delivered byte with the scoreboard
    task automatic drainTx(input int budget);
        tx_ready = 1'b1;
        for (int c = 0; c < budget && tx_valid; c++) begin
            if (txQ.size() == 0) begin
                assertions++;
                failures++;
                $display("[TB] FAIL txExtra: got 0x%0h required no byte", tx_data);
            end else begin
                checkOutput("txData", {24'h0, tx_data}, {24'h0, txQ.pop_front()});
            end
            @(posedge clk_in);
            #1;
        end
        tx_ready = 1'b0;
        checkOutput("txDrained", {31'h0, tx_valid}, 32'h0);
        checkOutput("txQueueLeft", txQ.size(), 32'h0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput(name, {3'b0, mem_din, tx_data, exit_code, tx_valid, io_buffer_full,
                           rx_pop, sim_done, tx_overflow}, 32'h0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 8'hA5, 8'h00};
        vecs[1]  = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
        vecs[2]  = '{1'b1, 32'h0000_0100, 8'h11, 8'h00};
        vecs[3]  = '{1'b1, 32'h0000_0101, 8'h22, 8'h00};
        vecs[4]  = '{1'b1, 32'h0000_0102, 8'h33, 8'h00};
        vecs[5]  = '{1'b1, 32'h0000_0103, 8'h44, 8'h00};
        vecs[6]  = '{1'b0, 32'h0000_0100, 8'h00, 8'h11};
        vecs[7]  = '{1'b0, 32'h0000_0101, 8'h00, 8'h22};
        vecs[8]  = '{1'b0, 32'h0000_0102, 8'h00, 8'h33};
        vecs[9]  = '{1'b0, 32'h0000_0103, 8'h00, 8'h44};
        vecs[10] = '{1'b1, 32'h0001_FFFF, 8'h5A, 8'h00};
        vecs[11] = '{1'b0, 32'h0001_FFFF, 8'h00, 8'h5A};
        vecs[12] = '{1'b0, 32'hFFF0_0010, 8'h00, 8'hA5};
        vecs[13] = '{1'b1, 32'h0003_0010, 8'hFF, 8'h00};
        vecs[14] = '{1'b0, 32'h0003_0010, 8'h00, 8'h00};
        vecs[15] = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};

        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        mem_a    = IDLE_ADDR;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #2;
        checkAllZero("resetState");
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Table-driven RAM and I/O decode vectors
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].data, !vecs[i].wr, vecs[i].expData);
        end

        // Disabled cycles: no push, mem_din holds
        rdy_in = 1'b0;
        applyStimulus(1'b1, 32'h0003_0000, 8'h99, 1'b0, 8'h00);
        applyStimulus(1'b0, 32'h0000_0100, 8'h00, 1'b0, 8'h00);
        checkOutput("rdyHoldDin", {24'h0, mem_din}, 32'hA5);
        checkOutput("rdyNoPush", {31'h0, tx_valid}, 32'h0);
        rdy_in = 1'b1;

        // Two TX pushes, a single pop, then drain
        txQ.push_back(8'h48);
        applyStimulus(1'b1, 32'h0003_0000, 8'h48, 1'b0, 8'h00);
        txQ.push_back(8'h69);
        applyStimulus(1'b1, 32'h0003_0000, 8'h69, 1'b0, 8'h00);
        checkOutput("txValid", {31'h0, tx_valid}, 32'h1);
        checkOutput("txHead", {24'h0, tx_data}, {24'h0, txQ[0]});
        tx_ready = 1'b1;
        void'(txQ.pop_front());
        @(posedge clk_in);
        #1;
        tx_ready = 1'b0;
        checkOutput("txHeadAfterPop", {24'h0, tx_data}, 32'h69);
        checkOutput("txValidAfterPop", {31'h0, tx_valid}, 32'h1);
        drainTx(8);

        // Fill the FIFO, watch the almost-full flag, then overflow it
        for (int k = 1; k <= 16; k++) begin
            txQ.push_back(8'h80 + 8'(k - 1));
            applyStimulus(1'b1, 32'h0003_0000, 8'h80 + 8'(k - 1), 1'b0, 8'h00);
            checkOutput($sformatf("ioBufferFull%0d", k), {31'h0, io_buffer_full}, (k >= 14) ? 32'h1 : 32'h0);
        end
        checkOutput("noOverflowYet", {31'h0, tx_overflow}, 32'h0);
        applyStimulus(1'b1, 32'h0003_0000, 8'hEE, 1'b0, 8'h00);
        checkOutput("overflowSet", {31'h0, tx_overflow}, 32'h1);

        // Push while full with a pop in the same cycle is accepted
        tx_ready = 1'b1;
        checkOutput("fullPopHead", {24'h0, tx_data}, {24'h0, txQ.pop_front()});
        txQ.push_back(8'h77);
        applyStimulus(1'b1, 32'h0003_0000, 8'h77, 1'b0, 8'h00);
        tx_ready = 1'b0;
        checkOutput("overflowSticky", {31'h0, tx_overflow}, 32'h1);
        checkOutput("stillAlmostFull", {31'h0, io_buffer_full}, 32'h1);
        drainTx(40);

        // RX byte available: pop pulse and next-cycle data
        rx_valid = 1'b1;
        rx_data  = 8'h3C;
        mem_wr   = 1'b0;
        mem_a    = 32'h0003_0000;
        #2;
        checkOutput("rxPopPulse", {31'h0, rx_pop}, 32'h1);
        readQ.push_back(8'h3C);
        @(posedge clk_in);
        #1;
        rx_valid = 1'b0;
        mem_a    = IDLE_ADDR;
        checkOutput("rxData", {24'h0, mem_din}, {24'h0, readQ.pop_front()});
        #1;
        checkOutput("rxPopEnds", {31'h0, rx_pop}, 32'h0);

        // RX read with nothing available
        rx_data = 8'h5D;
        mem_a   = 32'h0003_0000;
        #2;
        checkOutput("rxNoPop", {31'h0, rx_pop}, 32'h0);
        readQ.push_back(8'h00);
        @(posedge clk_in);
        #1;
        mem_a = IDLE_ADDR;
        checkOutput("rxEmptyData", {24'h0, mem_din}, {24'h0, readQ.pop_front()});

        // Fresh reset, then exactly 100 enabled cycles before the snapshot read
        rdy_in = 1'b0;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        rdy_in = 1'b1;
        repeat (100) @(posedge clk_in);
        #1;
        applyStimulus(1'b0, 32'h0003_0004, 8'h00, 1'b1, 8'h64);
        applyStimulus(1'b0, 32'h0003_0005, 8'h00, 1'b1, 8'h00);
        applyStimulus(1'b0, 32'h0003_0004, 8'h00, 1'b1, 8'h66);

        // Halt register
        checkOutput("simDoneClear", {31'h0, sim_done}, 32'h0);
        applyStimulus(1'b1, 32'h0003_0004, 8'h07, 1'b0, 8'h00);
        checkOutput("simDoneSet", {31'h0, sim_done}, 32'h1);
        checkOutput("exitCode", {24'h0, exit_code}, 32'h07);
        applyStimulus(1'b1, 32'h0003_0004, 8'h09, 1'b0, 8'h00);
        checkOutput("exitCodeUpdate", {24'h0, exit_code}, 32'h09);
        checkOutput("simDoneKept", {31'h0, sim_done}, 32'h1);

        // Mid-transaction asynchronous reset with FIFO data and a pending RX read
        applyStimulus(1'b1, 32'h0003_0000, 8'h55, 1'b0, 8'h00);
        applyStimulus(1'b0, 32'h0000_0010, 8'h00, 1'b1, 8'hA5);
        rx_valid = 1'b1;
        mem_a    = 32'h0003_0000;
        #3;
        rst_in = 1'b1;
        #1;
        checkAllZero("asyncResetImmediate");
        @(posedge clk_in);
        #1;
        checkAllZero("resetHeld");
        rx_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
